// File: rtl/cache_dir_assoc_if.sv
// rtl/cache_dir_assoc_if.sv - lookup/response/update bundle for the set-associative cache directory
interface cache_dir_assoc_if #(
  parameter int NUM_WAYS    = 4,
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 20,
  parameter int STATE_WIDTH = 2
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                   init_done;

  logic                   lookup_valid;
  logic                   lookup_ready;
  logic [INDEX_WIDTH-1:0] lookup_index;
  logic [TAG_WIDTH-1:0]   lookup_tag;

  logic                   rsp_valid;
  logic                   rsp_hit;
  logic [WAY_W-1:0]       rsp_way;
  logic [STATE_WIDTH-1:0] rsp_state;
  logic [TAG_WIDTH-1:0]   rsp_victim_tag;

  logic                   upd_valid;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic [WAY_W-1:0]       upd_way;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic [STATE_WIDTH-1:0] upd_state;

  modport master (
    input  init_done, lookup_ready,
    input  rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_victim_tag,
    output lookup_valid, lookup_index, lookup_tag,
    output upd_valid, upd_index, upd_way, upd_tag, upd_state
  );

  modport slave (
    output init_done, lookup_ready,
    output rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_victim_tag,
    input  lookup_valid, lookup_index, lookup_tag,
    input  upd_valid, upd_index, upd_way, upd_tag, upd_state
  );
endinterface

// File: rtl/cache_dir_assoc.sv
// rtl/cache_dir_assoc.sv - set-associative cache directory with tree-PLRU replacement
module cache_dir_assoc #(
  parameter int NUM_WAYS    = 4,
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 20,
  parameter int STATE_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_dir_assoc_if.slave bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int NODES = NUM_WAYS - 1;

  // Directory storage has no reset so it can map onto RAM; the sweep clears it.
  logic [TAG_WIDTH-1:0]   tag_mem   [SETS][NUM_WAYS];
  logic [STATE_WIDTH-1:0] state_mem [SETS][NUM_WAYS];
  logic [NODES-1:0]       plru_mem  [SETS];

  logic [INDEX_WIDTH-1:0] sweep_idx;
  logic                   init_done;
  logic                   accept;
  logic                   hit;
  logic                   free_found;
  logic [WAY_W-1:0]       hit_way;
  logic [WAY_W-1:0]       free_way;
  logic [WAY_W-1:0]       sel_way;
  logic [NODES-1:0]       set_plru;

  logic                   rsp_valid_q;
  logic                   rsp_hit_q;
  logic [WAY_W-1:0]       rsp_way_q;
  logic [STATE_WIDTH-1:0] rsp_state_q;
  logic [TAG_WIDTH-1:0]   rsp_victim_tag_q;

  // Walk the tree from the root following node pointers (0 = lower half).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    logic [WAY_W-1:0] way;
    logic             dir;
    int               node;
    way  = '0;
    node = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      dir = 1'b0;
      for (int j = 0; j < NODES; j++) begin
        if (j == node) dir = bits[j];
      end
      way[l] = dir;
      node   = 2 * node + 1 + int'(dir);
    end
    return way;
  endfunction

  // Make every node on the path to 'way' point at the other half.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] res;
    int               node;
    res  = bits;
    node = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      for (int j = 0; j < NODES; j++) begin
        if (j == node) res[j] = ~way[l];
      end
      node = 2 * node + 1 + int'(way[l]);
    end
    return res;
  endfunction

  assign bus.lookup_ready = init_done && !bus.upd_valid;
  assign accept           = bus.lookup_valid && bus.lookup_ready;

  // Probe the addressed set: lowest matching valid way, else lowest invalid way, else PLRU.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    set_plru   = plru_mem[bus.lookup_index];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (state_mem[bus.lookup_index][w] != '0 &&
          tag_mem[bus.lookup_index][w] == bus.lookup_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (state_mem[bus.lookup_index][w] == '0) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    sel_way = plru_victim(set_plru);
    if (hit) sel_way = hit_way;
    else if (free_found) sel_way = free_way;
  end

  // Storage writes: invalidation sweep, then updates, then hit-driven PLRU touches.
  always_ff @(posedge clk) begin
    if (!init_done) begin
      for (int w = 0; w < NUM_WAYS; w++) state_mem[sweep_idx][w] <= '0;
      plru_mem[sweep_idx] <= '0;
    end else if (bus.upd_valid) begin
      tag_mem[bus.upd_index][bus.upd_way]   <= bus.upd_tag;
      state_mem[bus.upd_index][bus.upd_way] <= bus.upd_state;
      if (bus.upd_state != '0)
        plru_mem[bus.upd_index] <= plru_touch(plru_mem[bus.upd_index], bus.upd_way);
    end else if (accept && hit) begin
      plru_mem[bus.lookup_index] <= plru_touch(set_plru, hit_way);
    end
  end

  // Sweep sequencing and the registered lookup response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx        <= '0;
      init_done        <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_hit_q        <= 1'b0;
      rsp_way_q        <= '0;
      rsp_state_q      <= '0;
      rsp_victim_tag_q <= '0;
    end else begin
      if (!init_done) begin
        sweep_idx <= sweep_idx + 1'b1;
        if (&sweep_idx) init_done <= 1'b1;
      end
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_hit_q        <= hit;
        rsp_way_q        <= sel_way;
        rsp_state_q      <= state_mem[bus.lookup_index][sel_way];
        rsp_victim_tag_q <= tag_mem[bus.lookup_index][sel_way];
      end
    end
  end

  assign bus.init_done      = init_done;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_hit        = rsp_hit_q;
  assign bus.rsp_way        = rsp_way_q;
  assign bus.rsp_state      = rsp_state_q;
  assign bus.rsp_victim_tag = rsp_victim_tag_q;
endmodule

// File: tb/tb_cache_dir_assoc.sv
// tb/tb_cache_dir_assoc.sv - randomized self-checking bench for cache_dir_assoc
module tb_cache_dir_assoc;
  localparam int NW   = 4;
  localparam int IW   = 7;
  localparam int TW   = 20;
  localparam int SW   = 2;
  localparam int SETS = 1 << IW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  cache_dir_assoc_if #(.NUM_WAYS(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .STATE_WIDTH(SW)) bus();

  cache_dir_assoc #(.NUM_WAYS(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .STATE_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference directory: tags, states, whether a tag was ever written, PLRU tree nodes.
  logic [TW-1:0] m_tag   [SETS][NW];
  logic [SW-1:0] m_state [SETS][NW];
  bit            m_known [SETS][NW];
  bit            m_plru  [SETS][NW-1];
  bit            last_hit;
  int            last_way;
  int            last_state;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Victim by interval halving: node n covers [lo, lo+size); pointer 1 means upper half.
  function automatic int m_walk(input int idx);
    int n, lo, size, half;
    n = 0; lo = 0; size = NW;
    while (size > 1) begin
      half = size / 2;
      if (m_plru[idx][n]) begin lo += half; n = 2 * n + 2; end
      else n = 2 * n + 1;
      size = half;
    end
    return lo;
  endfunction

  task automatic m_touch(input int idx, input int way);
    int n, lo, size, half;
    n = 0; lo = 0; size = NW;
    while (size > 1) begin
      half = size / 2;
      if (way < lo + half) begin m_plru[idx][n] = 1'b1; n = 2 * n + 1; end
      else begin m_plru[idx][n] = 1'b0; lo += half; n = 2 * n + 2; end
      size = half;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < NW; w++) begin m_state[s][w] = '0; m_known[s][w] = 1'b0; end
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 1'b0;
    end
    last_hit = 1'b0; last_way = 0; last_state = 0;
  endtask

  task automatic do_update(input int idx, input int way, input logic [TW-1:0] tg, input int st);
    bus.upd_index = IW'(idx);
    bus.upd_way   = 2'(way);
    bus.upd_tag   = tg;
    bus.upd_state = SW'(st);
    bus.upd_valid = 1'b1;
    #1 check("ready_during_upd", 64'(bus.lookup_ready), 64'(0));
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    m_tag[idx][way]   = tg;
    m_state[idx][way] = SW'(st);
    m_known[idx][way] = 1'b1;
    if (st != 0) m_touch(idx, way);
    check("no_rsp_after_upd", 64'(bus.rsp_valid), 64'(bus.lookup_valid ? 0 : 0));
  endtask

  task automatic do_lookup(input int idx, input logic [TW-1:0] tg);
    bit eh;
    int ew;
    eh = 1'b0; ew = -1;
    for (int w = 0; w < NW; w++)
      if (!eh && m_state[idx][w] != 0 && m_tag[idx][w] == tg) begin eh = 1'b1; ew = w; end
    if (!eh)
      for (int w = 0; w < NW; w++)
        if (ew < 0 && m_state[idx][w] == 0) ew = w;
    if (ew < 0) ew = m_walk(idx);
    bus.lookup_index = IW'(idx);
    bus.lookup_tag   = tg;
    bus.lookup_valid = 1'b1;
    #1 check("lookup_ready", 64'(bus.lookup_ready), 64'(1));
    @(posedge clk); #1;
    bus.lookup_valid = 1'b0;
    check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("rsp_hit", 64'(bus.rsp_hit), 64'(eh));
    check("rsp_way", 64'(bus.rsp_way), 64'(ew));
    check("rsp_state", 64'(bus.rsp_state), 64'(m_state[idx][ew]));
    if (m_known[idx][ew]) check("rsp_victim_tag", 64'(bus.rsp_victim_tag), 64'(m_tag[idx][ew]));
    if (eh) m_touch(idx, ew);
    last_hit = eh; last_way = ew; last_state = int'(m_state[idx][ew]);
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("hold_rsp_hit", 64'(bus.rsp_hit), 64'(last_hit));
    check("hold_rsp_way", 64'(bus.rsp_way), 64'(last_way));
    check("hold_rsp_state", 64'(bus.rsp_state), 64'(last_state));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_done"}, 64'(bus.init_done), 64'(0));
    check({tag, "_ready"}, 64'(bus.lookup_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_hit"}, 64'(bus.rsp_hit), 64'(0));
    check({tag, "_rsp_way"}, 64'(bus.rsp_way), 64'(0));
    check({tag, "_rsp_state"}, 64'(bus.rsp_state), 64'(0));
    check({tag, "_rsp_tag"}, 64'(bus.rsp_victim_tag), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, op, idx;
    bus.lookup_valid = 1'b0; bus.lookup_index = '0; bus.lookup_tag = '0;
    bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_way = '0;
    bus.upd_tag = '0; bus.upd_state = '0;
    m_clear();

    // Reset with a pending lookup held throughout reset and sweep.
    repeat (3) @(posedge clk);
    #1 bus.lookup_valid = 1'b1;
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.lookup_ready || bus.rsp_valid || bus.init_done) bad++;
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (!bus.init_done && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (!bus.init_done && (bus.lookup_ready || bus.rsp_valid)) bad++;
    end
    bus.lookup_valid = 1'b0;
    check("sweep_cycles", 64'(n), 64'(128));
    check("stall_during_sweep", 64'(bad), 64'(0));
    check("ready_after_init", 64'(bus.lookup_ready), 64'(1));

    // Directed: cold miss, update then hit, PLRU victim order, update/lookup collision.
    do_lookup(5, 20'h12345);
    do_idle();
    do_update(5, 2, 20'hABCDE, 1);
    do_lookup(5, 20'hABCDE);
    for (int w = 0; w < NW; w++) do_update(9, w, 20'h00100 + 20'(w), 1);
    do_lookup(9, 20'h00999);
    do_lookup(9, 20'h00100);
    do_lookup(9, 20'h00999);

    bus.upd_index = IW'(12); bus.upd_way = 2'd1; bus.upd_tag = 20'h0BEEF; bus.upd_state = 2'd3;
    bus.upd_valid = 1'b1;
    bus.lookup_index = IW'(12); bus.lookup_tag = 20'h0BEEF; bus.lookup_valid = 1'b1;
    #1 check("collide_ready", 64'(bus.lookup_ready), 64'(0));
    @(posedge clk); #1;
    check("collide_no_rsp", 64'(bus.rsp_valid), 64'(0));
    bus.upd_valid = 1'b0;
    m_tag[12][1] = 20'h0BEEF; m_state[12][1] = 2'd3; m_known[12][1] = 1'b1;
    m_touch(12, 1);
    do_lookup(12, 20'h0BEEF);

    // Randomized traffic concentrated on a few sets and a small tag pool.
    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 9));
      idx = (int'($urandom_range(0, 3)) == 3) ? 127 : int'($urandom_range(0, 2)) * 40 + 3;
      if (op < 4)
        do_update(idx, int'($urandom_range(0, NW - 1)), 20'h00200 + 20'($urandom_range(0, 7)),
                  (op == 0) ? 0 : int'($urandom_range(1, 3)));
      else if (op < 9)
        do_lookup(idx, 20'h00200 + 20'($urandom_range(0, 7)));
      else
        do_idle();
    end
    do_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_dir_assoc.md
CACHE_DIR_ASSOC -- requirements
Module: cache_dir_assoc

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of ways (power of two, 2..16).
REQ-002 SHALL have parameter INDEX_WIDTH, default 7, set-index width (2^INDEX_WIDTH sets).
REQ-003 SHALL have parameter TAG_WIDTH, default 20, tag width.
REQ-004 SHALL have parameter STATE_WIDTH, default 2, line-state width; encoding 0 = invalid.
REQ-005 SHALL have localparam WAY_W = log2(NUM_WAYS).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 init_done  out  1  high once the invalidation sweep has completed.
REQ-009 lookup_valid  in  1  lookup request.
REQ-010 lookup_ready  out  1  lookup accepted when valid && ready.
REQ-011 lookup_index  in  INDEX_WIDTH  set to probe.
REQ-012 lookup_tag  in  TAG_WIDTH  tag to compare.
REQ-013 rsp_valid  out  1  one-cycle response strobe.
REQ-014 rsp_hit  out  1  tag matched a valid way.
REQ-015 rsp_way  out  WAY_W  hit way on hit, victim way on miss.
REQ-016 rsp_state  out  STATE_WIDTH  state of rsp_way.
REQ-017 rsp_victim_tag  out  TAG_WIDTH  tag held in rsp_way (writeback address on miss).
REQ-018 upd_valid  in  1  directory write, always accepted once init_done = 1.
REQ-019 upd_index / upd_way / upd_tag / upd_state  in  INDEX_WIDTH / WAY_W / TAG_WIDTH / STATE_WIDTH  write target and contents.

Function
REQ-020 Storage SHALL hold per set: NUM_WAYS x {tag, state} plus NUM_WAYS-1 tree-PLRU bits; storage SHALL NOT be reset directly (RAM-mappable).
REQ-021 After rst_n deasserts, an INDEX_WIDTH-bit counter SHALL sweep sets 0..2^INDEX_WIDTH-1, one per cycle, writing state = 0 in every way and PLRU = 0.
REQ-022 init_done SHALL rise the cycle after set 2^INDEX_WIDTH-1 is written and stay high until reset; sweep takes exactly 2^INDEX_WIDTH cycles.
REQ-023 lookup_ready SHALL be init_done && !upd_valid (update has priority; a same-cycle lookup stalls).
REQ-024 upd_valid SHALL be ignored while init_done = 0.
REQ-025 Update SHALL write tag/state of (upd_index, upd_way) at the clock edge; if upd_state != 0, PLRU of that set SHALL be touched toward upd_way.
REQ-026 Accepted lookup SHALL read the set combinationally; response registered; rsp_valid high exactly one cycle after acceptance (latency 1, no response backpressure).
REQ-027 Hit = some way with state != 0 and tag == lookup_tag; on multiple matches rsp_way SHALL be the lowest-numbered match.
REQ-028 On hit, PLRU of the set SHALL be touched toward the hit way at the acceptance edge.
REQ-029 On miss, victim SHALL be the lowest-numbered way with state = 0; if none, the way selected by walking the PLRU tree; PLRU SHALL NOT change on miss.
REQ-030 PLRU touch SHALL set each node on the path to point away from the touched way; victim walk follows node pointers (0 = left/lower half).
REQ-031 Back-to-back: an update at edge N SHALL be visible to a lookup accepted at edge N+1 (no bypass needed, storage written at edge N).
REQ-032 Response outputs other than rsp_valid SHALL hold their last value when rsp_valid = 0.

Reset
REQ-033 While rst_n = 0: init_done = 0, lookup_ready = 0, rsp_valid = 0, rsp_hit = 0, rsp_way = 0, rsp_state = 0, rsp_victim_tag = 0, sweep counter = 0.
REQ-034 Reset asserted mid-sweep or mid-lookup SHALL abort immediately; the sweep restarts from set 0 after deassertion; no response is issued for an aborted lookup.

Verification
REQ-035 Reset then idle (INDEX_WIDTH = 7) -> init_done rises exactly 128 cycles after rst_n deasserts; lookup_ready = 0 throughout the sweep.
REQ-036 After init, lookup index 5 tag 0x12345 -> next cycle rsp_valid = 1, rsp_hit = 0, rsp_way = 0, rsp_state = 0.
REQ-037 Update (index 5, way 2, tag 0xABCDE, state 1), then lookup (5, 0xABCDE) the next cycle -> rsp_hit = 1, rsp_way = 2, rsp_state = 1.
REQ-038 Fill ways 0..3 of set 9 in order 0,1,2,3 (state 1), then miss lookup -> rsp_way = 0 (PLRU victim); after a hit on way 0, the next miss -> rsp_way = 2.
REQ-039 upd_valid and lookup_valid in the same cycle -> lookup_ready = 0, update applied, lookup accepted the following cycle with 1-cycle response.
REQ-040 rst_n pulsed low at sweep set 60 -> outputs return to reset values; init_done rises 128 cycles after the second deassertion.
